// File: rtl/systolic_output_deskew_if.sv
// Bus bundle between the skewed systolic result stream, the deskew FIFO
// and the downstream consumer.
interface systolic_output_deskew_if #(
  parameter int data_size = 16,
  parameter int size      = 3
);
  logic [data_size*size-1:0] acc_z_to_z;
  logic                      in_valid;
  logic [data_size*size-1:0] out_z;
  logic                      out_valid;
  logic                      out_ready;
  logic                      overflow;
  logic [15:0]               word_count;

  modport slave (
    input  acc_z_to_z, in_valid, out_ready,
    output out_z, out_valid, overflow, word_count
  );

  modport master (
    output acc_z_to_z, in_valid, out_ready,
    input  out_z, out_valid, overflow, word_count
  );
endinterface

// File: rtl/systolic_output_deskew.sv
// Realigns the lane-skewed systolic result vector into whole words and
// buffers them in a small FIFO with a valid/ready output.
module systolic_output_deskew #(
  parameter int data_size  = 16,
  parameter int size       = 3,
  parameter int fifo_depth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  systolic_output_deskew_if.slave bus
);
  localparam int AW = $clog2(fifo_depth);
  localparam int PW = AW + 1;
  localparam int WW = data_size * size;

  logic [WW-1:0]   aligned_word;
  logic [size-2:0] vld_q, vld_d;
  logic            push_en;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]   mem_q [fifo_depth];
  logic [WW-1:0]   mem_d [fifo_depth];
  logic            overflow_q, overflow_d;
  logic [15:0]     word_count_q, word_count_d;

  logic            empty_s, full_s, pop_s, push_s;

  // Lane k is delayed size-1-k cycles so every lane of a word meets lane size-1.
  for (genvar k = 0; k < size; k++) begin : g_lane
    localparam int depth = size - 1 - k;
    logic [data_size-1:0] lane_in;
    assign lane_in = bus.acc_z_to_z[data_size*(size-k)-1 -: data_size];

    if (depth == 0) begin : g_direct
      assign aligned_word[data_size*(size-k)-1 -: data_size] = lane_in;
    end else begin : g_pipe
      logic [data_size-1:0] pipe_q [depth];
      logic [data_size-1:0] pipe_d [depth];

      always_comb begin
        pipe_d[0] = lane_in;
        for (int s = 1; s < depth; s++) begin
          pipe_d[s] = pipe_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
      end

      assign aligned_word[data_size*(size-k)-1 -: data_size] = pipe_q[depth-1];
    end
  end

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = bus.in_valid;
    for (int i = 1; i < size - 1; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  assign push_en = vld_q[size-2];

  // A push into a full FIFO only survives if the head leaves on the same edge.
  always_comb begin
    empty_s      = (wr_ptr_q == rd_ptr_q);
    full_s       = ((wr_ptr_q - rd_ptr_q) == PW'(fifo_depth));
    pop_s        = !empty_s && bus.out_ready;
    push_s       = push_en && (!full_s || pop_s);

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    word_count_d = word_count_q;

    if (push_s) begin
      wr_ptr_d                = wr_ptr_q + PW'(1);
      mem_d[wr_ptr_q[AW-1:0]] = aligned_word;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      word_count_d = word_count_q + 16'd1;
    end else begin
      rd_ptr_d     = rd_ptr_q;
    end

    overflow_d = overflow_q | (push_en & full_s & ~pop_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      word_count_q <= 16'd0;
    end else begin
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.out_valid  = !empty_s;
  assign bus.out_z      = empty_s ? {WW{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.overflow   = overflow_q;
  assign bus.word_count = word_count_q;
endmodule

// File: doc/systolic_output_deskew.md
# systolic_output_deskew

Downstream stage of `systolic_array` in the backprop stack. It takes the skewed `acc_z_to_z` result vector, where lane k becomes valid k cycles after lane 0, and realigns all lanes into one word. It buffers aligned words in a small FIFO and hands them to the next stage over a valid/ready handshake. Words are Q(data_size/2).(data_size/2) fixed point and pass through unmodified.

## Interface
- `data_size`, 16, bits per lane.
- `size`, 3, lane count; must match `systolic_array`.
- `fifo_depth`, 4, aligned-word buffer entries; power of two, ≥2.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `acc_z_to_z`  in  data_size*size  skewed results; lane k = bits `[data_size*(size-k)-1 -: data_size]` (lane 0 in the MSBs).
- `in_valid`  in  1  high in the cycle lane 0 of a word is valid; lane k of that word is sampled k cycles later.
- `out_z`  out  data_size*size  aligned word at FIFO head, same lane packing; all zero when empty.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_z` when high together with `out_valid`.
- `overflow`  out  1  sticky; an aligned word was dropped because the FIFO was full.
- `word_count`  out  16  count of words popped; wraps modulo 2^16.

## Operation
- Deskew line:
  - Lane k passes through `size-1-k` register stages; lane `size-1` is unregistered at the push point.
  - `in_valid` passes through a `size-1` stage shift register. Its output `push_en` marks the cycle in which all lanes of one word are aligned.
- Push: when `push_en` is high, the aligned word is written at the FIFO tail.
- Pop: when `out_valid && out_ready` is high, the head advances and `word_count` increments.
- Full FIFO:
  - If `push_en` is high while full and no pop occurs in the same cycle, the word is dropped, `overflow` is set, and FIFO contents are unchanged.
  - If push and pop coincide while full, both take effect and `overflow` is unchanged.
- Empty FIFO: a push and an attempted pop in the same cycle perform the push only; there is no fall-through.
- `overflow` clears only on `reset`.
- Back-to-back `in_valid` is legal every cycle. Words stay in order and lanes never mix between words.
- Reset clears the `in_valid` shift register, FIFO pointers, `overflow` and `word_count`. Data registers need not clear. Words in flight at reset are discarded and never pushed.

## Timing
- Reset value of every output is 0: `out_z`, `out_valid`, `overflow`, `word_count`.
- `in_valid` high in cycle T (lane 0). Lane k is sampled in cycle T+k. Push occurs at the edge ending cycle T+size-1.
- Latency: `out_valid` rises in cycle T+size if the FIFO was empty.
- Throughput: one word per cycle sustained when `out_ready` is held high.
- `out_z`/`out_valid` come from registered pointers and storage. They change only on clock edges.
- `overflow` is visible in the cycle after the dropped push.
- `word_count` updates on the same edge as the pop.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs. Require `out_valid`=0, `out_z`=0, `overflow`=0 and `word_count`=0.
- Single word:
  - Stimulus: `in_valid`=1 in cycle 0 with lane0=0x0100, cycle 1 lane1=0x0200, cycle 2 lane2=0x0300, `out_ready`=1.
  - Required: `out_valid` high only in cycle 3 with `out_z`=0x0100_0200_0300; `word_count`=1 afterward.
- Streaming:
  - Stimulus: 8 consecutive words, lane values = 16·n+k, `out_ready`=1.
  - Required: outputs in cycles 3–10, exact values, in order, `overflow`=0.
- Overflow:
  - Stimulus: `out_ready`=0, 5 back-to-back words.
  - Required: `overflow`=1 after cycle 7; then draining returns exactly words 0–3 and `word_count`=4.
- Full with simultaneous pop and push:
  - Stimulus: fill 4 words, then assert `out_ready` exactly in the cycle `push_en` of word 4 fires.
  - Required: word 0 popped, word 4 stored, `overflow`=0, later drain returns words 1–4.
- Reset mid-operation: assert `reset` in cycle 1 of a word's skew window. Require no output ever appears for that word, and the next word after reset aligns normally.
